// File: rtl/nn_pkg.sv
// Shared definitions for the neuron_unit front end.
// Provides the image geometry, pixel/line types and the packer FSM state enum.
package nn_pkg;

    localparam int IMG_ROWS = 28;
    localparam int IMG_COLS = 28;
    localparam int PIX_W    = 8;
    localparam int LINE_W   = 224;

    // Index widths wide enough for 0..27.
    localparam int ROW_W    = 5;
    localparam int COL_W    = 5;
    localparam int HOLD_W   = 16;

    typedef logic [PIX_W-1:0]  pix_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

endpackage

// File: rtl/pixel_frame_ctrl.sv
// Control path of pixel_frame_packer: FILL/HOLD state machine, row/column
// position counters, de hold counter, completed-frame counter and the
// mid-frame SOF error pulse.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   pix_valid_i         pixel offered this cycle
//   pix_sof_i           offered pixel is frame position (0,0)
//   pix_ready_o         FILL state: a pixel can be accepted
//   de_o                HOLD state: frame lines are valid
//   sof_err_o           one-cycle pulse after an SOF that aborted a frame
//   frame_cnt_o         completed frames, wrapping
//   wr_en_o             pixel accepted this cycle
//   wr_row_o, wr_col_o  line register position for the accepted pixel
module pixel_frame_ctrl
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 25,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_valid_i,
    input  logic                   pix_sof_i,
    output logic                   pix_ready_o,
    output logic                   de_o,
    output logic                   sof_err_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic                   wr_en_o,
    output logic [ROW_W-1:0]       wr_row_o,
    output logic [COL_W-1:0]       wr_col_o
);

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_ROWS - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_COLS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    packer_state_t          state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [FRAME_CNT_W-1:0] frame_q, frame_d;
    logic                   sof_err_q, sof_err_d;
    logic                   accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            row_q     <= '0;
            col_q     <= '0;
            hold_q    <= '0;
            frame_q   <= '0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            hold_q    <= hold_d;
            frame_q   <= frame_d;
            sof_err_q <= sof_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        hold_d    = hold_q;
        frame_d   = frame_q;
        sof_err_d = 1'b0;

        accept    = pix_valid_i && (state_q == FILL);
        wr_en_o   = accept;
        // SOF redirects the write to (0,0) regardless of the current position.
        wr_row_o  = pix_sof_i ? '0 : row_q;
        wr_col_o  = pix_sof_i ? '0 : col_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    if (pix_sof_i) begin
                        // SOF takes priority, even over the last pixel of a frame.
                        row_d     = '0;
                        col_d     = COL_W'(1);
                        sof_err_d = (row_q != '0) || (col_q != '0);
                    end else if (col_q == LAST_COL) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) begin
                            row_d   = '0;
                            state_d = HOLD;
                            frame_d = frame_q + FRAME_CNT_W'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = FILL;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Handshake and frame-valid are pure decodes of the state register.
    assign pix_ready_o = (state_q == FILL);
    assign de_o        = (state_q == HOLD);
    assign sof_err_o   = sof_err_q;
    assign frame_cnt_o = frame_q;

endmodule

// File: rtl/pixel_frame_packer.sv
// Packs a row-major 8-bit pixel stream into 28 registered 224-bit lines
// (one 28x28 frame) and presents them, frozen, with de_out high for
// HOLD_CYCLES cycles once the frame is complete.
//
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   pix_valid/pix_data     pixel stream, accepted when pix_ready is high
//   pix_sof                marks the offered pixel as (0,0)
//   pix_ready              stream open (FILL)
//   line_k_out (k=0..27)   row k; column 0 in [223:216], column 27 in [7:0]
//   de_out                 frame valid, to neuron_unit de_in
//   sof_err                pulse after an SOF that aborted a partial frame
//   frame_cnt              completed frames, wrapping
module pixel_frame_packer
    import nn_pkg::*;
#(
    parameter int HOLD_CYCLES = 25,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_valid,
    input  pix_t                   pix_data,
    input  logic                   pix_sof,
    output logic                   pix_ready,
    output line_t                  line_0_out,
    output line_t                  line_1_out,
    output line_t                  line_2_out,
    output line_t                  line_3_out,
    output line_t                  line_4_out,
    output line_t                  line_5_out,
    output line_t                  line_6_out,
    output line_t                  line_7_out,
    output line_t                  line_8_out,
    output line_t                  line_9_out,
    output line_t                  line_10_out,
    output line_t                  line_11_out,
    output line_t                  line_12_out,
    output line_t                  line_13_out,
    output line_t                  line_14_out,
    output line_t                  line_15_out,
    output line_t                  line_16_out,
    output line_t                  line_17_out,
    output line_t                  line_18_out,
    output line_t                  line_19_out,
    output line_t                  line_20_out,
    output line_t                  line_21_out,
    output line_t                  line_22_out,
    output line_t                  line_23_out,
    output line_t                  line_24_out,
    output line_t                  line_25_out,
    output line_t                  line_26_out,
    output line_t                  line_27_out,
    output logic                   de_out,
    output logic                   sof_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    line_t            lines_q [IMG_ROWS];

    pixel_frame_ctrl #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .FRAME_CNT_W (FRAME_CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .pix_valid_i (pix_valid),
        .pix_sof_i   (pix_sof),
        .pix_ready_o (pix_ready),
        .de_o        (de_out),
        .sof_err_o   (sof_err),
        .frame_cnt_o (frame_cnt),
        .wr_en_o     (wr_en),
        .wr_row_o    (wr_row),
        .wr_col_o    (wr_col)
    );

    // Byte-addressed write: each byte lane has its own row/column match, so
    // only the accepted pixel's lane loads and everything else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                lines_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < IMG_ROWS; r++) begin
                for (int c = 0; c < IMG_COLS; c++) begin
                    if (wr_en && (wr_row == ROW_W'(r)) && (wr_col == COL_W'(c))) begin
                        lines_q[r][(IMG_COLS-1-c)*PIX_W +: PIX_W] <= pix_data;
                    end
                end
            end
        end
    end

    assign line_0_out  = lines_q[0];
    assign line_1_out  = lines_q[1];
    assign line_2_out  = lines_q[2];
    assign line_3_out  = lines_q[3];
    assign line_4_out  = lines_q[4];
    assign line_5_out  = lines_q[5];
    assign line_6_out  = lines_q[6];
    assign line_7_out  = lines_q[7];
    assign line_8_out  = lines_q[8];
    assign line_9_out  = lines_q[9];
    assign line_10_out = lines_q[10];
    assign line_11_out = lines_q[11];
    assign line_12_out = lines_q[12];
    assign line_13_out = lines_q[13];
    assign line_14_out = lines_q[14];
    assign line_15_out = lines_q[15];
    assign line_16_out = lines_q[16];
    assign line_17_out = lines_q[17];
    assign line_18_out = lines_q[18];
    assign line_19_out = lines_q[19];
    assign line_20_out = lines_q[20];
    assign line_21_out = lines_q[21];
    assign line_22_out = lines_q[22];
    assign line_23_out = lines_q[23];
    assign line_24_out = lines_q[24];
    assign line_25_out = lines_q[25];
    assign line_26_out = lines_q[26];
    assign line_27_out = lines_q[27];

endmodule

// File: doc/pixel_frame_packer.md
Name: pixel_frame_packer

Overview:
- Front-end feeder for neuron_unit. Accepts a row-major 8-bit pixel stream over a valid/ready handshake.
- Assembles one 28x28 frame into 28 registered 224-bit lines.
- When the frame is complete, drives de_out high for a fixed hold window and presents the frozen lines, so neuron_unit's symbol scores can settle.
- Then re-opens the stream for the next frame.

Parameters:
- HOLD_CYCLES, 25, cycles de_out stays high per frame; legal range 1..2^16-1.
- FRAME_CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pix_valid  in  1  pixel data valid.
- pix_data  in  8  pixel value.
- pix_sof  in  1  qualified by pix_valid; marks the pixel as frame pixel (0,0).
- pix_ready  out  1  block accepts a pixel this cycle.
- line_k_out, k=0..27  out  224 each  row k; column 0 in bits [223:216], column 27 in bits [7:0].
- de_out  out  1  frame valid; connects to neuron_unit de_in.
- sof_err  out  1  one-cycle pulse: SOF received mid-frame.
- frame_cnt  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - all line_k_out = 0, de_out = 0, sof_err = 0, frame_cnt = 0.
  - row = col = 0, hold_cnt = 0, state = FILL, pix_ready = 1 once reset deasserts.
- Accept condition: a pixel is accepted on a rising edge where pix_valid & pix_ready. Nothing else changes the line registers.
- FILL state:
  - pix_ready = 1, de_out = 0.
  - On accept, pix_data is written to line_row_out[(27-col)*8 +: 8].
  - col increments; at col=27 it wraps to 0 and row increments.
- SOF handling in FILL:
  - pix_sof with an accept forces the write to (0,0) and sets col=1, row=0.
  - If (row,col) was not (0,0) at that moment, sof_err pulses high the following cycle.
  - Pixels already written from the aborted frame are not cleared; they are overwritten as the new frame fills.
- Frame completion:
  - Accepting pixel (27,27) moves state to HOLD on the same edge.
  - frame_cnt increments; row and col clear.
  - Latency: de_out is high in the cycle immediately after the edge that accepted the last pixel. All 28 lines are already final in that cycle.
- HOLD state:
  - pix_ready = 0 and de_out = 1; the lines are frozen.
  - hold_cnt counts 0..HOLD_CYCLES-1, so de_out is high for exactly HOLD_CYCLES cycles.
  - On the last count, state returns to FILL and hold_cnt clears. de_out = 0 and pix_ready = 1 in the next cycle.
  - pix_valid and pix_sof are ignored (not accepted) during HOLD.
- Outputs are not cleared on return to FILL; they hold the previous frame until overwritten pixel by pixel.
- All outputs are registered; pix_ready and de_out decode directly from the state register.
- Reset asserted mid-frame or mid-HOLD clears everything immediately. No partial frame is counted.
- Simultaneous SOF on the last-position pixel (27,27): SOF wins. Write goes to (0,0), sof_err pulses, and no frame completion occurs.

Decomposition:
- Shared package nn_pkg:
  - IMG_ROWS=28, IMG_COLS=28, PIX_W=8, LINE_W=224.
  - typedef pix_t (logic [7:0]) and line_t (logic [223:0]).
  - enum packer_state_t {FILL, HOLD}.
- One sub-module, pixel_frame_ctrl:
  - contains the FSM, row/col counters, hold counter, frame counter and sof_err.
  - outputs a write strobe plus row/col indices.
- The top holds the 28x224 line register array and the write decode.

Test Plan:
1. Reset: hold reset=0, then release -> all lines 0, de_out=0, pix_ready=1, frame_cnt=0, sof_err=0.
2. Continuous stream of 784 pixels, value = (row*28+col) mod 256, sof on the first pixel:
   - de_out rises the cycle after the 784th accept.
   - line_0_out[223:216]=0x00, line_0_out[7:0]=0x1B, line_27_out[7:0]=0x0F.
   - de_out high exactly 25 cycles, pix_ready=0 throughout, frame_cnt=1.
3. Same frame with random pix_valid gaps (about 30% idle) -> identical line contents; de_out one cycle after the final accept.
4. SOF asserted on the 101st pixel:
   - sof_err pulses for 1 cycle; that pixel lands at (0,0).
   - de_out only after 783 further accepts; frame_cnt=1.
5. reset dropped during HOLD at hold cycle 10 -> de_out=0 and lines=0 asynchronously, frame_cnt=0; the next full frame completes normally.
6. Two back-to-back frames with pix_valid held high across HOLD:
   - no accepts during HOLD; the second frame starts the cycle pix_ready returns.
   - frame_cnt=2; line contents match the second frame.
